// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants for the GPR write-port scheduler and its scoreboard.
package regfile_wb_sched_pkg;

    localparam int ADDR_WIDTH_DEF   = 5;
    localparam int DATA_WIDTH_DEF   = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    // Register 0 is hardwired zero: never written, never pending.
    localparam int REG_ZERO = 0;

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Bundle of issue, pipeline writeback, long-unit and regfile write signals.
//
// Handshake: the long unit holds l_valid/l_addr/l_data stable until it sees
// l_ready=1 in the same cycle; the transfer happens on that rising edge.
// The pipeline writeback (p_we) has no ready: it always wins the port.
// Decode holds its instruction while iss_stall=1; issue fires on the edge
// where iss_valid=1 and iss_stall=0.
interface regfile_wb_sched_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_s_addr;
    logic [ADDR_WIDTH-1:0] iss_t_addr;
    logic [ADDR_WIDTH-1:0] iss_d_addr;
    logic                  iss_long;
    logic                  iss_stall;
    logic                  hold;
    logic                  p_we;
    logic [ADDR_WIDTH-1:0] p_addr;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  l_valid;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [DATA_WIDTH-1:0] l_data;
    logic                  l_ready;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_data;
    logic                  err;

    // Environment side: decode, WB stage, long unit and regfile.
    modport master (
        output iss_valid, iss_s_addr, iss_t_addr, iss_d_addr, iss_long,
        output p_we, p_addr, p_data,
        output l_valid, l_addr, l_data,
        input  iss_stall, hold, l_ready, d_we, d_addr, d_data, err
    );

    // Scheduler side.
    modport slave (
        input  iss_valid, iss_s_addr, iss_t_addr, iss_d_addr, iss_long,
        input  p_we, p_addr, p_data,
        input  l_valid, l_addr, l_data,
        output iss_stall, hold, l_ready, d_we, d_addr, d_data, err
    );

endinterface

// File: rtl/regfile_wb_sched_scoreboard.sv
// Pending-destination vector for long-latency results: one bit per GPR,
// a set port (issue), a clear port (long grant) and three lookup ports.
module regfile_wb_sched_scoreboard
    import regfile_wb_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         set_en,
    input  logic [ADDR_WIDTH-1:0]        set_addr,
    input  logic                         clr_en,
    input  logic [ADDR_WIDTH-1:0]        clr_addr,
    input  logic [ADDR_WIDTH-1:0]        a_addr,
    input  logic [ADDR_WIDTH-1:0]        b_addr,
    input  logic [ADDR_WIDTH-1:0]        c_addr,
    output logic                         a_hit,
    output logic                         b_hit,
    output logic                         c_hit,
    output logic [(1<<ADDR_WIDTH)-1:0]   pending
);

    localparam int NREG = 1 << ADDR_WIDTH;

    // Bit 0 is forced low so register 0 can never look pending.
    localparam logic [NREG-1:0] LIVE_MASK = ~(NREG'(1) << REG_ZERO);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Decode the set/clear addresses into one-hot masks.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
    end

    // Pending vector: clear first, then set, register 0 masked off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= ((pend_q & ~clr_mask) | set_mask) & LIVE_MASK;
        end
    end

    assign a_hit   = pend_q[a_addr];
    assign b_hit   = pend_q[b_addr];
    assign c_hit   = pend_q[c_addr];
    assign pending = pend_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-port scheduler for the 2R/1W GPR file: arbitrates the single write
// port between pipeline writeback and the long-latency unit, tracks pending
// long destinations and stalls issue on RAW/WAW hazards against them.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_sched_if.slave  bus
);

    localparam int                    CW    = cnt_width(STARVE_LIMIT);
    localparam logic [CW-1:0]         LIMIT = CW'(STARVE_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(REG_ZERO);

    logic                         grant_p;
    logic                         grant_l;
    logic                         l_nonzero;
    logic                         hit_s;
    logic                         hit_t;
    logic                         hit_d;
    logic                         issue_fire;
    logic                         set_en;
    logic                         clr_en;
    logic [(1<<ADDR_WIDTH)-1:0]   pending;
    logic [CW-1:0]                starve_cnt;
    logic [CW-1:0]                starve_nxt;
    logic                         hold_q;
    logic                         err_q;

    regfile_wb_sched_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_addr (bus.iss_d_addr),
        .clr_en   (clr_en),
        .clr_addr (bus.l_addr),
        .a_addr   (bus.iss_s_addr),
        .b_addr   (bus.iss_t_addr),
        .c_addr   (bus.iss_d_addr),
        .a_hit    (hit_s),
        .b_hit    (hit_t),
        .c_hit    (hit_d),
        .pending  (pending)
    );

    // Issue hazard check and scoreboard set/clear requests.
    always_comb begin
        bus.iss_stall = bus.iss_valid & (hit_s | hit_t | hit_d);
        issue_fire    = bus.iss_valid & ~bus.iss_stall;
        set_en        = issue_fire & bus.iss_long & (bus.iss_d_addr != ZERO);
        l_nonzero     = bus.l_addr != ZERO;
        clr_en        = grant_l & l_nonzero;
    end

    // Port arbitration: pipeline always wins, long unit takes idle cycles.
    // Writes to register 0 are accepted but never reach the regfile.
    always_comb begin
        grant_p     = bus.p_we;
        grant_l     = ~bus.p_we & bus.l_valid;
        bus.l_ready = grant_l;
        bus.d_addr  = grant_p ? bus.p_addr : bus.l_addr;
        bus.d_data  = grant_p ? bus.p_data : bus.l_data;
        bus.d_we    = (grant_p & (bus.p_addr != ZERO)) | (grant_l & l_nonzero);
    end

    // Next value of the consecutive-denial counter, saturating at the limit.
    always_comb begin
        starve_nxt = starve_cnt;
        if (grant_l || !bus.l_valid) begin
            starve_nxt = '0;
        end else if (starve_cnt != LIMIT) begin
            starve_nxt = starve_cnt + CW'(1);
        end
    end

    // Starvation counter, hold request and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            if (grant_l) begin
                hold_q <= 1'b0;
            end else if (starve_nxt == LIMIT) begin
                hold_q <= 1'b1;
            end
            if (clr_en && !pending[bus.l_addr]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.hold = hold_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios followed by random traffic,
// all compared against a set-based reference model of the scheduler.
module tb_regfile_wb_sched;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    regfile_wb_sched #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model / scoreboard ----------------
    int errors = 0;
    int checks = 0;
    bit pend_m [1<<AW];
    int run_m;
    bit hold_m;
    bit err_m;
    logic [AW+DW-1:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        run_m  = 0;
        hold_m = 1'b0;
        err_m  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.iss_valid  = 1'b0;
        bus.iss_s_addr = '0;
        bus.iss_t_addr = '0;
        bus.iss_d_addr = '0;
        bus.iss_long   = 1'b0;
        bus.p_we       = 1'b0;
        bus.p_addr     = '0;
        bus.p_data     = '0;
        bus.l_valid    = 1'b0;
        bus.l_addr     = '0;
        bus.l_data     = '0;
    endtask

    task automatic issue(input int s, input int t, input int d, input bit lng);
        bus.iss_valid  = 1'b1;
        bus.iss_s_addr = AW'(s);
        bus.iss_t_addr = AW'(t);
        bus.iss_d_addr = AW'(d);
        bus.iss_long   = lng;
    endtask

    // Check the combinational outputs for the current inputs, advance the
    // model across one rising edge, check the registered outputs, and return
    // at the following falling edge ready for new inputs.
    task automatic cycle();
        bit exp_stall, exp_lr, exp_we, fire;
        int s, t, d, la;
        logic [AW+DW-1:0] wr;
        #1;
        s  = int'(bus.iss_s_addr);
        t  = int'(bus.iss_t_addr);
        d  = int'(bus.iss_d_addr);
        la = int'(bus.l_addr);
        exp_stall = bus.iss_valid && (pend_m[s] || pend_m[t] || pend_m[d]);
        exp_lr    = !bus.p_we && bus.l_valid;
        exp_we    = 1'b0;
        if (bus.p_we) begin
            exp_we = (bus.p_addr != '0);
            wr     = {bus.p_addr, bus.p_data};
        end else if (bus.l_valid) begin
            exp_we = (la != 0);
            wr     = {bus.l_addr, bus.l_data};
        end
        chk("iss_stall", bus.iss_stall, exp_stall);
        chk("l_ready", bus.l_ready, exp_lr);
        chk("d_we", bus.d_we, exp_we);
        if (exp_we) exp_q.push_back(wr);
        if (exp_q.size() == 0) begin
            chk("d_spurious", bus.d_we, 1'b0);
        end else if (bus.d_we) begin
            chk("d_write", {bus.d_addr, bus.d_data}, exp_q.pop_front());
        end
        exp_q.delete();
        // model state update, all from pre-edge values
        fire = bus.iss_valid && !exp_stall;
        if (exp_lr) begin
            if (la != 0) begin
                if (!pend_m[la]) err_m = 1'b1;
                pend_m[la] = 1'b0;
            end
            hold_m = 1'b0;
            run_m  = 0;
        end else if (bus.l_valid && bus.p_we) begin
            run_m++;
            if (run_m >= LIMIT) hold_m = 1'b1;
        end else begin
            run_m = 0;
        end
        if (fire && bus.iss_long && d != 0) pend_m[d] = 1'b1;
        @(posedge clk);
        #1;
        chk("hold", bus.hold, hold_m);
        chk("err", bus.err, err_m);
        @(negedge clk);
    endtask

    // Pick a long-result address: usually a pending register, sometimes random.
    function automatic int pick_laddr();
        int start;
        start = $urandom_range(1, (1<<AW)-1);
        if ($urandom_range(0, 9) != 0) begin
            for (int k = 0; k < (1<<AW); k++) begin
                int r;
                r = (start + k) % (1<<AW);
                if (pend_m[r]) return r;
            end
        end
        return $urandom_range(0, 15);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        // reset state: nothing pending, all handshake outputs low
        issue(5, 9, 1, 1'b0);
        #1;
        chk("rst_stall", bus.iss_stall, 1'b0);
        chk("rst_l_ready", bus.l_ready, 1'b0);
        chk("rst_d_we", bus.d_we, 1'b0);
        chk("rst_hold", bus.hold, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: RAW on a long destination, cleared by the long grant
        issue(1, 2, 5, 1'b1);
        cycle();
        issue(5, 0, 6, 1'b0);
        #1 chk("t1_stall", bus.iss_stall, 1'b1);
        cycle();
        bus.l_valid = 1'b1; bus.l_addr = 5'd5; bus.l_data = 32'hDEADBEEF;
        #1;
        chk("t1_d_we", bus.d_we, 1'b1);
        chk("t1_d_addr", bus.d_addr, 5'd5);
        chk("t1_d_data", bus.d_data, 32'hDEADBEEF);
        chk("t1_l_ready", bus.l_ready, 1'b1);
        cycle();
        bus.l_valid = 1'b0;
        #1 chk("t1_unstall", bus.iss_stall, 1'b0);
        cycle();
        idle();

        // 2: pipeline beats the long unit, long unit takes the next free cycle
        issue(0, 0, 7, 1'b1);
        cycle();
        idle();
        bus.p_we = 1'b1; bus.p_addr = 5'd3; bus.p_data = 32'h1234_5678;
        bus.l_valid = 1'b1; bus.l_addr = 5'd7; bus.l_data = 32'h0BAD_F00D;
        #1;
        chk("t2_d_addr_p", bus.d_addr, 5'd3);
        chk("t2_l_ready_p", bus.l_ready, 1'b0);
        cycle();
        bus.p_we = 1'b0;
        #1;
        chk("t2_d_addr_l", bus.d_addr, 5'd7);
        chk("t2_l_ready_l", bus.l_ready, 1'b1);
        cycle();
        idle();

        // 3: starvation raises hold after LIMIT denied cycles
        issue(0, 0, 10, 1'b1);
        cycle();
        idle();
        bus.p_we = 1'b1; bus.p_addr = 5'd1; bus.p_data = 32'h1;
        bus.l_valid = 1'b1; bus.l_addr = 5'd10; bus.l_data = 32'hA5A5_0010;
        repeat (LIMIT - 1) cycle();
        chk("t3_hold_early", bus.hold, 1'b0);
        cycle();
        chk("t3_hold_set", bus.hold, 1'b1);
        bus.p_we = 1'b0;
        #1 chk("t3_l_ready", bus.l_ready, 1'b1);
        cycle();
        chk("t3_hold_clr", bus.hold, 1'b0);
        idle();

        // 4: register 0 is never pending and never written
        issue(0, 0, 0, 1'b1);
        cycle();
        issue(0, 0, 0, 1'b0);
        #1 chk("t4_stall", bus.iss_stall, 1'b0);
        bus.l_valid = 1'b1; bus.l_addr = '0; bus.l_data = 32'hFFFF_FFFF;
        #1;
        chk("t4_l_ready", bus.l_ready, 1'b1);
        chk("t4_d_we", bus.d_we, 1'b0);
        cycle();
        chk("t4_err", bus.err, 1'b0);
        idle();

        // 5: WAW stall, stray result sets sticky err
        issue(0, 0, 9, 1'b1);
        cycle();
        issue(1, 2, 9, 1'b0);
        #1 chk("t5_waw_stall", bus.iss_stall, 1'b1);
        cycle();
        bus.l_valid = 1'b1; bus.l_addr = 5'd12; bus.l_data = 32'hC0FFEE;
        cycle();
        chk("t5_err", bus.err, 1'b1);
        bus.l_addr = 5'd9; bus.l_data = 32'h9999;
        #1 chk("t5_still_stall", bus.iss_stall, 1'b1);
        cycle();
        bus.l_valid = 1'b0;
        #1 chk("t5_unstall", bus.iss_stall, 1'b0);
        cycle();
        chk("t5_err_sticky", bus.err, 1'b1);
        idle();

        // 6: asynchronous reset in the middle of a stall with hold and err up
        issue(0, 0, 4, 1'b1);
        cycle();
        issue(0, 0, 9, 1'b1);
        cycle();
        idle();
        bus.p_we = 1'b1; bus.p_addr = 5'd2;
        bus.l_valid = 1'b1; bus.l_addr = 5'd9;
        repeat (LIMIT) cycle();
        issue(4, 0, 1, 1'b0);
        #1;
        chk("t6_pre_stall", bus.iss_stall, 1'b1);
        chk("t6_pre_hold", bus.hold, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_stall", bus.iss_stall, 1'b0);
        chk("t6_rst_hold", bus.hold, 1'b0);
        chk("t6_rst_err", bus.err, 1'b0);
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(4, 0, 1, 1'b0);
        #1 chk("t6_after_rst", bus.iss_stall, 1'b0);
        cycle();
        idle();

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0) begin
                issue($urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end
            if (!hold_m || $urandom_range(0, 7) == 0) begin
                bus.p_we = 1'($urandom_range(0, 9) < 4);
            end
            bus.p_addr  = AW'($urandom_range(0, 15));
            bus.p_data  = $urandom;
            bus.l_valid = 1'($urandom_range(0, 1));
            bus.l_addr  = AW'(pick_laddr());
            bus.l_data  = $urandom;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
